// File: rtl/lfsr_crc_frame_checker.sv
// Receive-side frame checker: recomputes the CRC-16 over payload beats, checks
// the trailing CRC beat and LFSR sequence continuity, and strobes one result per frame.
module lfsr_crc_frame_checker #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           LFSR_WIDTH = 16,
    parameter logic [15:0]           CRC_POLY   = 16'h8005,
    parameter logic [LFSR_WIDTH-1:0] CRC_INIT   = '1,
    parameter int unsigned           LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  data_valid,
    input  logic                  frame_sof,
    input  logic                  frame_eof,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [LFSR_WIDTH-1:0] seq_in,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  crc_ok,
    output logic                  crc_err,
    output logic                  seq_err,
    output logic [LFSR_WIDTH-1:0] crc_calc,
    output logic [LEN_WIDTH-1:0]  frame_len,
    output logic [7:0]            sof_err_cnt
);

    localparam logic [LFSR_WIDTH-1:0] POLY    = LFSR_WIDTH'(CRC_POLY);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE = LEN_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t                state;
    logic [LFSR_WIDTH-1:0] crc;
    logic [LFSR_WIDTH-1:0] rx_crc;
    logic [LFSR_WIDTH-1:0] exp_seq;
    logic [LEN_WIDTH-1:0]  len;
    logic                  seq_flag;

    // One payload byte into the CRC, LSB first.
    function automatic logic [LFSR_WIDTH-1:0] crc_step(input logic [LFSR_WIDTH-1:0] c_in,
                                                       input logic [7:0]            d);
        logic [LFSR_WIDTH-1:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[LFSR_WIDTH-1] ^ d[i]) c = (c << 1) ^ POLY;
            else                        c = c << 1;
        end
        return c;
    endfunction

    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] l);
        return {l[LFSR_WIDTH-2:0], l[LFSR_WIDTH-1] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            crc         <= CRC_INIT;
            rx_crc      <= '0;
            exp_seq     <= '0;
            len         <= '0;
            seq_flag    <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            crc_ok      <= 1'b0;
            crc_err     <= 1'b0;
            seq_err     <= 1'b0;
            crc_calc    <= '0;
            frame_len   <= '0;
            sof_err_cnt <= 8'd0;
        end else begin
            frame_done <= 1'b0;
            crc_ok     <= 1'b0;
            crc_err    <= 1'b0;
            seq_err    <= 1'b0;

            if (state == CHECK) begin
                // Single evaluation cycle; any beat offered here is a protocol violation.
                frame_done <= 1'b1;
                crc_err    <= (crc != rx_crc);
                seq_err    <= seq_flag;
                crc_ok     <= (crc == rx_crc) && !seq_flag;
                crc_calc   <= crc;
                frame_len  <= len;
                state      <= IDLE;
                busy       <= 1'b0;
                if (data_valid) sof_err_cnt <= sat_inc(sof_err_cnt);
            end else if (data_valid) begin
                if (frame_sof) begin
                    // Start (or restart from RECV) a frame.
                    if (state == RECV) sof_err_cnt <= sat_inc(sof_err_cnt);
                    seq_flag <= 1'b0;
                    busy     <= 1'b1;
                    if (frame_eof) begin
                        rx_crc <= data_in[LFSR_WIDTH-1:0];
                        crc    <= CRC_INIT;
                        len    <= '0;
                        state  <= CHECK;
                    end else begin
                        crc     <= crc_step(CRC_INIT, data_in[7:0]);
                        exp_seq <= lfsr_next(seq_in);
                        len     <= LEN_ONE;
                        state   <= RECV;
                    end
                end else if (state == IDLE) begin
                    sof_err_cnt <= sat_inc(sof_err_cnt);
                end else begin
                    // Resync on every beat so a single dropped step flags only once.
                    if (seq_in != exp_seq) seq_flag <= 1'b1;
                    exp_seq <= lfsr_next(seq_in);
                    if (frame_eof) begin
                        rx_crc <= data_in[LFSR_WIDTH-1:0];
                        state  <= CHECK;
                    end else begin
                        crc <= crc_step(crc, data_in[7:0]);
                        if (len != '1) len <= len + LEN_ONE;
                    end
                end
            end
        end
    end

    generate
        if (DATA_WIDTH > LFSR_WIDTH) begin : g_data_hi
            logic unused_data_hi;
            assign unused_data_hi = ^data_in[DATA_WIDTH-1:LFSR_WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_lfsr_crc_frame_checker.sv
// Scoreboard bench for lfsr_crc_frame_checker: frame results are predicted at
// stimulus time and compared when frame_done strobes.
module tb_lfsr_crc_frame_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_valid;
    logic        frame_sof;
    logic        frame_eof;
    logic [31:0] data_in;
    logic [15:0] seq_in;
    logic        busy;
    logic        frame_done;
    logic        crc_ok;
    logic        crc_err;
    logic        seq_err;
    logic [15:0] crc_calc;
    logic [7:0]  frame_len;
    logic [7:0]  sof_err_cnt;

    typedef struct packed {
        logic        ok;
        logic        cerr;
        logic        serr;
        logic [15:0] crc;
        logic [7:0]  len;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    lfsr_crc_frame_checker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_valid (data_valid),
        .frame_sof  (frame_sof),
        .frame_eof  (frame_eof),
        .data_in    (data_in),
        .seq_in     (seq_in),
        .busy       (busy),
        .frame_done (frame_done),
        .crc_ok     (crc_ok),
        .crc_err    (crc_err),
        .seq_err    (seq_err),
        .crc_calc   (crc_calc),
        .frame_len  (frame_len),
        .sof_err_cnt(sof_err_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference CRC-16 over one byte, reflected input, poly 0x8005.
    function automatic logic [15:0] model_crc(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h8005;
        end
        return c;
    endfunction

    // Taps 15,13,12,10 as a mask.
    function automatic logic [15:0] model_next(input logic [15:0] l);
        return {l[14:0], ^(l & 16'hB400)};
    endfunction

    task automatic set_in(input bit v, input bit sof, input bit eof,
                          input logic [31:0] d, input logic [15:0] s);
        data_valid = v;
        frame_sof  = sof;
        frame_eof  = eof;
        data_in    = d;
        seq_in     = s;
    endtask

    always @(negedge clk) begin
        if (rst_n && frame_done) begin
            if (sb.size() == 0) begin
                check_val("spurious_done", 32'(frame_done), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check_val("crc_ok",    32'(crc_ok),    32'(mon_e.ok));
                check_val("crc_err",   32'(crc_err),   32'(mon_e.cerr));
                check_val("seq_err",   32'(seq_err),   32'(mon_e.serr));
                check_val("crc_calc",  32'(crc_calc),  32'(mon_e.crc));
                check_val("frame_len", 32'(frame_len), 32'(mon_e.len));
            end
        end
    end

    // Full frame: n payload beats then the CRC beat. skip_idx>0 skips one LFSR
    // step before beat skip_idx (beat n is the CRC beat).
    task automatic run_frame(input int n, input logic [15:0] seq0, input int skip_idx,
                             input bit corrupt, input bit zero_data);
        logic [15:0] s;
        logic [15:0] c;
        logic [31:0] d;
        exp_t        e;
        s = seq0;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            d = zero_data ? 32'd0 : $urandom();
            c = model_crc(c, d[7:0]);
            @(negedge clk);
            set_in(1'b1, i == 0, 1'b0, d, s);
            s = model_next(s);
            if (i + 1 == skip_idx) s = model_next(s);
        end
        e.crc  = c;
        e.len  = 8'(n);
        e.cerr = corrupt;
        e.serr = (skip_idx >= 1) && (skip_idx <= n);
        e.ok   = !e.cerr && !e.serr;
        sb.push_back(e);
        @(negedge clk);
        check_val("busy_in_frame", 32'(busy), 32'd1);
        set_in(1'b1, 1'b0, 1'b1, {16'($urandom()), c ^ 16'(corrupt)}, s);
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
        check_val("done_early", 32'(frame_done), 32'd0);
        @(negedge clk);
        check_val("done_strobe", 32'(frame_done), 32'd1);
        @(negedge clk);
        check_val("done_clear", 32'(frame_done), 32'd0);
        check_val("ok_clear", 32'(crc_ok | crc_err | seq_err), 32'd0);
        check_val("crc_hold", 32'(crc_calc), 32'(c));
        check_val("len_hold", 32'(frame_len), 32'(n));
    endtask

    task automatic zero_frame(input logic [15:0] rx);
        exp_t e;
        e.crc  = 16'hFFFF;
        e.len  = 8'd0;
        e.cerr = (rx != 16'hFFFF);
        e.serr = 1'b0;
        e.ok   = (rx == 16'hFFFF);
        sb.push_back(e);
        @(negedge clk);
        set_in(1'b1, 1'b1, 1'b1, {16'hA5A5, rx}, 16'h1234);
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_flags"}, 32'({frame_done, crc_ok, crc_err, seq_err}), 32'd0);
        check_val({tag, "_crc_calc"}, 32'(crc_calc), 32'd0);
        check_val({tag, "_frame_len"}, 32'(frame_len), 32'd0);
        check_val({tag, "_sof_err_cnt"}, 32'(sof_err_cnt), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Single zero byte: CRC 0xFD02, then the same frame with a bad CRC.
        run_frame(1, 16'hACE1, 0, 1'b0, 1'b1);
        check_val("single_crc_const", 32'(crc_calc), 32'h0000FD02);
        run_frame(1, 16'hACE1, 0, 1'b1, 1'b1);
        check_val("badcrc_crc_const", 32'(crc_calc), 32'h0000FD02);

        zero_frame(16'hFFFF);
        zero_frame(16'h0000);

        // Sequence break on the second payload beat.
        run_frame(3, 16'hACE1, 1, 1'b0, 1'b0);

        // Protocol violations: stray beat in IDLE, beat during CHECK, sof inside RECV.
        check_val("proto_cnt_start", 32'(sof_err_cnt), 32'd0);
        @(negedge clk);
        set_in(1'b1, 1'b0, 1'b0, $urandom(), 16'h0001);
        sb.push_back('{ok: 1'b1, cerr: 1'b0, serr: 1'b0, crc: 16'hFFFF, len: 8'd0});
        @(negedge clk);
        set_in(1'b1, 1'b1, 1'b1, 32'h0000FFFF, 16'h0002);
        @(negedge clk);
        set_in(1'b1, 1'b0, 1'b0, $urandom(), 16'h0003);
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
        @(negedge clk);
        check_val("proto_cnt_two", 32'(sof_err_cnt), 32'd2);
        set_in(1'b1, 1'b1, 1'b0, $urandom(), 16'h5555);
        run_frame(2, 16'h1111, 0, 1'b0, 1'b0);
        check_val("proto_cnt_three", 32'(sof_err_cnt), 32'd3);

        // Reset after two payload beats discards the frame.
        @(negedge clk);
        set_in(1'b1, 1'b1, 1'b0, $urandom(), 16'hACE1);
        @(negedge clk);
        set_in(1'b1, 1'b0, 1'b0, $urandom(), model_next(16'hACE1));
        @(negedge clk);
        set_in(1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_all_zero("midreset");
        repeat (3) @(negedge clk);
        run_frame(4, 16'hBEEF, 0, 1'b0, 1'b0);

        // Randomised frames with occasional skips and corruption.
        for (int k = 0; k < 6; k++) begin
            n = $urandom_range(1, 6);
            run_frame(n, 16'($urandom_range(1, 65535)), $urandom_range(0, n + 2),
                      1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (3) @(negedge clk);
        check_val("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_crc_frame_checker.md
Name: lfsr_crc_frame_checker

Overview:
- Receive-side counterpart of the LFSR/CRC stream generator.
- Consumes framed payload beats, each tagged with an LFSR sequence value, and recomputes the CRC-16 the transmitter produced.
- Checks the trailing CRC beat and the continuity of the LFSR sequence.
- Reports one pass/fail result per frame to the downstream status logic.

Parameters:
DATA_WIDTH, 32, payload beat width; must be >= LFSR_WIDTH
LFSR_WIDTH, 16, CRC and sequence LFSR width; must be >= 16
CRC_POLY, 16'h8005, CRC polynomial, zero-extended to LFSR_WIDTH
CRC_INIT, all ones, CRC preset at frame start
LEN_WIDTH, 8, frame length counter width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
data_valid  in  1  beat qualifier
frame_sof  in  1  first beat of frame (qualified by data_valid)
frame_eof  in  1  CRC beat, last of frame (qualified by data_valid)
data_in  in  DATA_WIDTH  payload beat; on eof beat, [LFSR_WIDTH-1:0] = transmitted CRC
seq_in  in  LFSR_WIDTH  transmitter LFSR value for this beat
busy  out  1  frame in progress (state != IDLE)
frame_done  out  1  one-cycle result strobe
crc_ok  out  1  valid with frame_done: CRC matched and no sequence error
crc_err  out  1  valid with frame_done: CRC mismatch
seq_err  out  1  valid with frame_done: sequence break seen in frame
crc_calc  out  LFSR_WIDTH  computed CRC; held until next frame_done
frame_len  out  LEN_WIDTH  payload beats in frame; held until next frame_done
sof_err_cnt  out  8  count of protocol violations, saturating

Behaviour:
- Reset (rst_n low at posedge): state IDLE, CRC = CRC_INIT, all outputs 0, expected sequence = 0. Reset mid-frame discards the frame; no frame_done.
- Accepted beat: data_valid = 1 while in IDLE or RECV. Beats in CHECK are not accepted.
- CRC update per payload beat:
  - Process data_in[7:0] LSB first, bit i = 0..7.
  - If crc[MSB] ^ data_in[i]: crc = (crc << 1) ^ CRC_POLY; else crc = crc << 1.
- Sequence LFSR: next(l) = {l[W-2:0], l[W-1]^l[13]^l[12]^l[10]}.
- FSM states IDLE, RECV, CHECK.
- IDLE:
  - Accepted beat with sof and no eof: CRC = update(CRC_INIT, beat); expected_seq = next(seq_in); len = 1; seq_flag = 0; go to RECV.
  - sof and eof on the same beat: zero-length frame. Compare data_in[LFSR_WIDTH-1:0] against CRC_INIT; len = 0; go to CHECK.
  - Beat without sof: dropped; sof_err_cnt++.
- RECV, beat without eof:
  - CRC updated; len++ (saturating at all ones).
  - seq_in != expected_seq sets seq_flag. expected_seq = next(seq_in) (resync, so one drop flags once).
  - A beat with sof restarts the frame exactly as in IDLE and increments sof_err_cnt.
- RECV, beat with eof:
  - Latch received CRC from data_in[LFSR_WIDTH-1:0].
  - eof beat seq_in is checked like a payload beat; it does not update CRC or len.
  - Go to CHECK.
- CHECK (exactly one cycle):
  - Compare computed vs received CRC.
  - At end of CHECK, register frame_done = 1, crc_err = mismatch, seq_err = seq_flag, crc_ok = !mismatch & !seq_flag, crc_calc, frame_len.
  - Return to IDLE.
  - A data_valid beat during CHECK is dropped and increments sof_err_cnt.
- Latency: eof accepted at edge N; frame_done high during the cycle after edge N+1, for exactly one cycle. An sof may be accepted at edge N+2.
- frame_done, crc_ok, crc_err and seq_err clear the cycle after the strobe. crc_calc and frame_len hold until the next strobe.
- sof_err_cnt saturates at 255; cleared only by reset.

Test Plan:
- Single byte: sof beat data_in = 0x00, then eof beat data_in[15:0] = 0xFD02, consecutive seq_in (0xACE1, then its LFSR successor) -> frame_done 2 cycles after eof edge, crc_ok = 1, crc_calc = 0xFD02, frame_len = 1.
- Bad CRC: same frame, eof carries 0xFD03 -> crc_err = 1, crc_ok = 0, crc_calc = 0xFD02.
- Zero-length: sof+eof on one beat with data_in[15:0] = 0xFFFF -> crc_ok = 1, frame_len = 0; with 0x0000 -> crc_err = 1.
- Sequence break: 3-beat payload where beat 2 seq_in skips one LFSR step -> seq_err = 1, crc_ok = 0, crc_err = 0 given a correct CRC.
- Protocol: beat without sof in IDLE, then beat during CHECK, then sof inside RECV -> sof_err_cnt = 3; restarted frame checks correctly.
- Reset mid-frame: rst_n low for one cycle after 2 payload beats -> no frame_done, all outputs 0; next full frame passes.
